// File: rtl/tick_rate_controller.sv
// Timebase for the counter: divides fast_clock into a one-cycle tick and a square-wave
// slow_clock, sequencing run / pause / single-step / clear with tick-aligned rate changes.
module tick_rate_controller #(
    parameter int DIV_WIDTH = 26,
    parameter int RATE0_DIV = 50_000_000,
    parameter int RATE1_DIV = 5_000_000,
    parameter int RATE2_DIV = 500_000,
    parameter int RATE3_DIV = 50_000
) (
    input  logic       fast_clock,
    input  logic       rst,
    input  logic       run_cmd,
    input  logic       pause_cmd,
    input  logic       step_cmd,
    input  logic       clear_cmd,
    input  logic [1:0] rate_sel,
    input  logic       rate_load,
    output logic       tick,
    output logic       slow_clock,
    output logic [1:0] state,
    output logic [1:0] active_rate,
    output logic       rate_pending
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_STEP  = 2'b11
    } state_t;

    localparam logic [DIV_WIDTH-1:0] CNT_ZERO = DIV_WIDTH'(0);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1);

    state_t               state_r;
    logic [DIV_WIDTH-1:0] cnt_r;
    logic                 tick_r;
    logic                 slow_r;
    logic [1:0]           active_r;
    logic [1:0]           pend_rate_r;
    logic                 pending_r;

    logic [DIV_WIDTH-1:0] cur_last_s;
    logic [DIV_WIDTH-1:0] pend_last_s;
    logic [DIV_WIDTH-1:0] cnt_fix_s;
    logic                 wrap_s;
    logic                 apply_s;

    function automatic logic [DIV_WIDTH-1:0] div_of(input logic [1:0] idx);
        case (idx)
            2'd0:    div_of = DIV_WIDTH'(RATE0_DIV);
            2'd1:    div_of = DIV_WIDTH'(RATE1_DIV);
            2'd2:    div_of = DIV_WIDTH'(RATE2_DIV);
            2'd3:    div_of = DIV_WIDTH'(RATE3_DIV);
            default: div_of = DIV_WIDTH'(RATE0_DIV);
        endcase
    endfunction

    // Wrap detection and rate-apply decision; a pending rate is taken at the tick boundary in RUN, at once elsewhere
    always_comb begin
        cur_last_s  = div_of(active_r) - CNT_ONE;
        pend_last_s = div_of(pend_rate_r) - CNT_ONE;
        wrap_s      = (state_r == ST_RUN) && !clear_cmd && !pause_cmd && (cnt_r == cur_last_s);
        apply_s     = pending_r && ((state_r != ST_RUN) || wrap_s);
        if (apply_s && (cnt_r >= pend_last_s)) begin
            cnt_fix_s = CNT_ZERO;
        end else begin
            cnt_fix_s = cnt_r;
        end
    end

    // Sequencer, divide counter and rate bookkeeping
    always_ff @(posedge fast_clock) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            tick_r      <= 1'b0;
            slow_r      <= 1'b0;
            active_r    <= 2'd0;
            pend_rate_r <= 2'd0;
            pending_r   <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (apply_s) begin
                active_r <= pend_rate_r;
            end
            // A load on the apply edge stays pending for the next boundary
            if (rate_load) begin
                pend_rate_r <= rate_sel;
                pending_r   <= 1'b1;
            end else if (apply_s) begin
                pending_r <= 1'b0;
            end

            if (clear_cmd) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        cnt_r <= CNT_ZERO;
                        if (pause_cmd) begin
                            state_r <= ST_PAUSE;
                        end else if (run_cmd) begin
                            state_r <= ST_RUN;
                        end else if (step_cmd) begin
                            state_r <= ST_STEP;
                            tick_r  <= 1'b1;
                            slow_r  <= ~slow_r;
                        end
                    end
                    ST_RUN: begin
                        if (pause_cmd) begin
                            state_r <= ST_PAUSE;
                        end else if (wrap_s) begin
                            cnt_r  <= CNT_ZERO;
                            tick_r <= 1'b1;
                            slow_r <= ~slow_r;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ST_PAUSE: begin
                        cnt_r <= cnt_fix_s;
                        if (pause_cmd) begin
                            state_r <= ST_PAUSE;
                        end else if (run_cmd) begin
                            state_r <= ST_RUN;
                        end else if (step_cmd) begin
                            state_r <= ST_STEP;
                            tick_r  <= 1'b1;
                            slow_r  <= ~slow_r;
                        end
                    end
                    ST_STEP: begin
                        cnt_r   <= cnt_fix_s;
                        state_r <= ST_PAUSE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    assign tick         = tick_r;
    assign slow_clock   = slow_r;
    assign state        = state_r;
    assign active_rate  = active_r;
    assign rate_pending = pending_r;

endmodule

// File: tb/tb_tick_rate_controller.sv
// Directed scenarios plus random command traffic, compared cycle by cycle against a
// behavioural model of the tick/rate rules.
module tb_tick_rate_controller;

    logic       clk = 1'b0;
    logic       rst, run_cmd, pause_cmd, step_cmd, clear_cmd, rate_load;
    logic [1:0] rate_sel;
    logic       tick, slow_clock, rate_pending;
    logic [1:0] state, active_rate;

    int checks = 0;
    int errors = 0;

    tick_rate_controller #(
        .DIV_WIDTH(8), .RATE0_DIV(4), .RATE1_DIV(3), .RATE2_DIV(1), .RATE3_DIV(10)
    ) dut (
        .fast_clock(clk), .rst(rst), .run_cmd(run_cmd), .pause_cmd(pause_cmd),
        .step_cmd(step_cmd), .clear_cmd(clear_cmd), .rate_sel(rate_sel),
        .rate_load(rate_load), .tick(tick), .slow_clock(slow_clock), .state(state),
        .active_rate(active_rate), .rate_pending(rate_pending)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode, cycles elapsed in the current tick period, rates in use/waiting
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_STEP = 3;
    int rates [4] = '{4, 3, 1, 10};
    int m_mode, m_pos, m_rate, m_pend_rate;
    bit m_pend, m_tick, m_slow;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  period, next_mode, next_pos;
        bit  boundary, take_rate;
        if (rst) begin
            m_mode = M_IDLE; m_pos = 0; m_rate = 0; m_pend_rate = 0;
            m_pend = 0; m_tick = 0; m_slow = 0;
            return;
        end
        period    = rates[m_rate];
        boundary  = (m_mode == M_RUN) && !clear_cmd && !pause_cmd && (m_pos + 1 == period);
        take_rate = m_pend && ((m_mode != M_RUN) || boundary);
        next_mode = m_mode;
        next_pos  = m_pos;
        m_tick    = 0;
        if (clear_cmd) begin
            next_mode = M_IDLE;
            next_pos  = 0;
        end else if (m_mode == M_RUN) begin
            if (pause_cmd) next_mode = M_PAUSE;
            else if (boundary) begin
                next_pos = 0; m_tick = 1; m_slow = !m_slow;
            end else next_pos = m_pos + 1;
        end else begin
            if (take_rate && m_pos >= rates[m_pend_rate] - 1) next_pos = 0;
            if (m_mode == M_IDLE) next_pos = 0;
            if (m_mode == M_STEP) next_mode = M_PAUSE;
            else if (pause_cmd) next_mode = M_PAUSE;
            else if (run_cmd) next_mode = M_RUN;
            else if (step_cmd) begin
                next_mode = M_STEP; m_tick = 1; m_slow = !m_slow;
            end
        end
        if (take_rate) m_rate = m_pend_rate;
        if (rate_load) begin
            m_pend_rate = int'(rate_sel); m_pend = 1;
        end else if (take_rate) m_pend = 0;
        m_mode = next_mode;
        m_pos  = next_pos;
    endtask

    // One clock: drive inputs, let model and DUT take the edge, then compare on the falling edge
    task automatic cyc(input logic r, input logic ru, input logic pa, input logic st,
                       input logic cl, input logic ld, input logic [1:0] sel);
        rst = r; run_cmd = ru; pause_cmd = pa; step_cmd = st; clear_cmd = cl;
        rate_load = ld; rate_sel = sel;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("tick", 32'(tick), 32'(m_tick));
        check_eq("slow_clock", 32'(slow_clock), 32'(m_slow));
        check_eq("state", 32'(state), 32'(m_mode));
        check_eq("active_rate", 32'(active_rate), 32'(m_rate));
        check_eq("rate_pending", 32'(rate_pending), 32'(m_pend));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        rst = 1'b1; run_cmd = 1'b0; pause_cmd = 1'b0; step_cmd = 1'b0;
        clear_cmd = 1'b0; rate_load = 1'b0; rate_sel = 2'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check_eq("reset_state", 32'(state), 32'd0);
        check_eq("reset_slow", 32'(slow_clock), 32'd0);

        // Run at rate 0: ticks 4, 8, 12 cycles after entry
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            check_eq("t1_tick", 32'(tick), 32'((i % 4) == 0));
            check_eq("t1_state", 32'(state), 32'd1);
        end
        check_eq("t1_slow", 32'(slow_clock), 32'd1);

        // Load rate 1 at cnt=1: pending two cycles, applied with the next tick
        idle(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        check_eq("t2_pend_a", 32'(rate_pending), 32'd1);
        check_eq("t2_rate_a", 32'(active_rate), 32'd0);
        idle(1);
        check_eq("t2_pend_b", 32'(rate_pending), 32'd1);
        idle(1);
        check_eq("t2_pend_c", 32'(rate_pending), 32'd0);
        check_eq("t2_rate_c", 32'(active_rate), 32'd1);
        check_eq("t2_tick_c", 32'(tick), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            check_eq("t2_tick3", 32'(tick), 32'((i % 3) == 0));
        end

        // Back to rate 0, pause at cnt=2, hold, resume
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        idle(2);
        check_eq("t3_rate0", 32'(active_rate), 32'd0);
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            idle(1);
            check_eq("t3_hold", 32'(tick), 32'd0);
        end
        check_eq("t3_pause", 32'(state), 32'd2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        idle(1);
        check_eq("t3_resume_a", 32'(tick), 32'd0);
        idle(1);
        check_eq("t3_resume_b", 32'(tick), 32'd1);

        // Three spaced single steps from PAUSE, then resume confirms cnt held at 2
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int s = 0; s < 3; s++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            check_eq("t4_step_state", 32'(state), 32'd3);
            check_eq("t4_step_tick", 32'(tick), 32'd1);
            idle(1);
            check_eq("t4_back_state", 32'(state), 32'd2);
            check_eq("t4_back_tick", 32'(tick), 32'd0);
            idle(2);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        idle(1);
        check_eq("t4_cnt_a", 32'(tick), 32'd0);
        idle(1);
        check_eq("t4_cnt_b", 32'(tick), 32'd1);

        // Clear with run at cnt=3 suppresses the tick
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        check_eq("t5_tick", 32'(tick), 32'd0);
        check_eq("t5_state", 32'(state), 32'd0);

        // Divide-by-one: tick every cycle; then reset mid-run
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check_eq("t6_tick", 32'(tick), 32'd1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check_eq("t6_rst_tick", 32'(tick), 32'd0);
        check_eq("t6_rst_state", 32'(state), 32'd0);
        check_eq("t6_rst_rate", 32'(active_rate), 32'd0);
        check_eq("t6_rst_pend", 32'(rate_pending), 32'd0);

        // Random command traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 11) == 0),
                2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
